// File: rtl/ifid_queue_if.sv
// Fetch/decode handshake bundle for ifid_queue: fetch push side, decode pop side,
// plus status. The queue takes the slave modport; the fetch/decode environment takes master.
interface ifid_queue_if #(
  parameter int DEPTH = 4,
  parameter int IW    = 32,
  parameter int PW    = 32
);
  logic                       push;
  logic [IW-1:0]              instr_in;
  logic [PW-1:0]              npc_in;
  logic                       pop;
  logic                       flush;
  logic                       ready;
  logic                       out_valid;
  logic [IW-1:0]              instr_out;
  logic [PW-1:0]              npc_out;
  logic [$clog2(DEPTH):0]     count;
  logic                       halted;

  modport master (
    output push, instr_in, npc_in, pop, flush,
    input  ready, out_valid, instr_out, npc_out, count, halted
  );

  modport slave (
    input  push, instr_in, npc_in, pop, flush,
    output ready, out_valid, instr_out, npc_out, count, halted
  );
endinterface

// File: rtl/ifid_queue.sv
// DEPTH-entry fetch/decode queue of {instruction, next-PC} with flush and halt detection.
// Optional zero-latency empty-queue bypass is enabled by defining IFQ_BYPASS_EN.
module ifid_queue #(
  parameter int         DEPTH   = 4,
  parameter int         IW      = 32,
  parameter int         PW      = 32,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic          CLK,
  input  logic          nRST,
  ifid_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [IW+PW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_halted;

  logic             w_empty;
  logic             w_ready;
  logic             w_accept;
  logic             w_bypass;
  logic             w_byp_take;
  logic             w_write;
  logic             w_remove;
  logic             w_halt_hit;
  logic [CW-1:0]    w_count_nxt;
  logic [IW+PW-1:0] w_head;

  always_comb begin
    w_empty  = (r_count == '0);
    w_ready  = ~r_halted & ((r_count != FULL_CNT) | bus.pop);
    w_accept = bus.push & w_ready & ~bus.flush;
`ifdef IFQ_BYPASS_EN
    w_bypass = w_empty & bus.push & ~bus.flush & w_ready;
`else
    w_bypass = 1'b0;
`endif
    // A bypassed entry that decode takes immediately never touches storage.
    w_byp_take = w_bypass & bus.pop;
    w_write    = w_accept & ~w_byp_take;
    w_remove   = bus.pop & ~w_empty & ~bus.flush;
    w_halt_hit = w_accept & (bus.instr_in[IW-1 -: 6] == HALT_OP);
    w_head     = r_mem[r_rd_ptr];

    w_count_nxt = r_count;
    case ({w_write, w_remove})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  assign bus.ready     = w_ready;
  assign bus.count     = r_count;
  assign bus.halted    = r_halted;
  assign bus.out_valid = ~w_empty | w_bypass;
  assign bus.instr_out = ~w_empty ? w_head[IW+PW-1:PW] : (w_bypass ? bus.instr_in : '0);
  assign bus.npc_out   = ~w_empty ? w_head[PW-1:0]     : (w_bypass ? bus.npc_in   : '0);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_write)    r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_remove)   r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      if (w_halt_hit) r_halted <= 1'b1;
    end
  end

  // Storage is not reset; entries are only meaningful under r_count.
  always_ff @(posedge CLK) begin
    if (nRST && w_write) r_mem[r_wr_ptr] <= {bus.instr_in, bus.npc_in};
  end
endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_ifid_queue;
  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int PW    = 32;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  ifid_queue_if #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) ifc ();

  ifid_queue #(.DEPTH(DEPTH), .IW(IW), .PW(PW), .HALT_OP(6'b111111)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (ifc)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  bit          m_halt;

  logic        obs_v, obs_r, obs_h;
  logic [31:0] obs_i, obs_n;
  int          obs_c;

  typedef struct {
    bit          p;
    logic [31:0] i;
    logic [31:0] n;
    bit          po;
    bit          f;
    bit          ev;
    logic [31:0] ei;
    logic [31:0] en;
    int          ec;
    bit          er;
    bit          eh;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit p, logic [31:0] i, logic [31:0] n, bit po, bit f,
                              bit ev, logic [31:0] ei, logic [31:0] en, int ec, bit er, bit eh);
    vec_t v;
    v.p = p; v.i = i; v.n = n; v.po = po; v.f = f;
    v.ev = ev; v.ei = ei; v.en = en; v.ec = ec; v.er = er; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check(input bit p, input logic [31:0] i, input logic [31:0] n,
                             input bit po, input bit f);
    int sz;
    bit rdy, byp, ev;
    logic [31:0] ei, en;
    sz  = q.size();
    rdy = !m_halt && (sz < DEPTH || po);
    byp = BYP && sz == 0 && p && !f && rdy;
    ev  = (sz > 0) || byp;
    ei  = (sz > 0) ? q[0][63:32] : (byp ? i : 32'h0);
    en  = (sz > 0) ? q[0][31:0]  : (byp ? n : 32'h0);
    chk("m_valid",  obs_v, ev);
    chk("m_instr",  obs_i, ei);
    chk("m_npc",    obs_n, en);
    chk("m_count",  obs_c, sz);
    chk("m_ready",  obs_r, rdy);
    chk("m_halted", obs_h, m_halt);
  endtask

  task automatic model_update(input bit rn, input bit p, input logic [31:0] i,
                              input logic [31:0] n, input bit po, input bit f);
    int sz;
    bit rdy, acc;
    sz = q.size();
    if (!rn || f) begin
      q.delete();
      m_halt = 1'b0;
      return;
    end
    rdy = !m_halt && (sz < DEPTH || po);
    acc = p && rdy;
    if (BYP && sz == 0 && acc && po) begin
      // consumed straight through, nothing stored
    end else begin
      if (po && sz > 0) void'(q.pop_front());
      if (acc) q.push_back({i, n});
    end
    if (acc && i[31:26] == 6'b111111) m_halt = 1'b1;
  endtask

  task automatic cyc(input bit rn, input bit p, input logic [31:0] i, input logic [31:0] n,
                     input bit po, input bit f);
    @(negedge CLK);
    nRST = rn; ifc.push = p; ifc.instr_in = i; ifc.npc_in = n; ifc.pop = po; ifc.flush = f;
    #1;
    obs_v = ifc.out_valid; obs_i = ifc.instr_out; obs_n = ifc.npc_out;
    obs_c = int'(ifc.count); obs_r = ifc.ready; obs_h = ifc.halted;
    if (rn) model_check(p, i, n, po, f);
    @(posedge CLK);
    model_update(rn, p, i, n, po, f);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit b;
    b = BYP;
    nRST = 1'b0; ifc.push = 0; ifc.instr_in = 0; ifc.npc_in = 0; ifc.pop = 0; ifc.flush = 0;
    q.delete(); m_halt = 0;

    tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 32'h2001_0005, 32'h4, 0, 0,
                 b, b ? 32'h2001_0005 : 32'h0, b ? 32'h4 : 32'h0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,  1, 32'h2001_0005, 32'h4, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0,  1, 32'h2001_0005, 32'h4, 1, 1, 0);
    tbl[4]  = mk(1, 32'h1, 32'h104, 0, 0,
                 b, b ? 32'h1 : 32'h0, b ? 32'h104 : 32'h0, 0, 1, 0);
    tbl[5]  = mk(1, 32'h2, 32'h108, 0, 0,  1, 32'h1, 32'h104, 1, 1, 0);
    tbl[6]  = mk(1, 32'h3, 32'h10c, 0, 0,  1, 32'h1, 32'h104, 2, 1, 0);
    tbl[7]  = mk(1, 32'h4, 32'h110, 0, 0,  1, 32'h1, 32'h104, 3, 1, 0);
    tbl[8]  = mk(1, 32'h5, 32'h114, 0, 0,  1, 32'h1, 32'h104, 4, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0,  1, 32'h1, 32'h104, 4, 1, 0);
    tbl[10] = mk(0, 0, 0, 1, 0,  1, 32'h2, 32'h108, 3, 1, 0);
    tbl[11] = mk(0, 0, 0, 1, 0,  1, 32'h3, 32'h10c, 2, 1, 0);
    tbl[12] = mk(0, 0, 0, 1, 0,  1, 32'h4, 32'h110, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

    cyc(0, 1, 32'hDEAD_BEEF, 32'h8, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 14; k++) begin
      cyc(1, tbl[k].p, tbl[k].i, tbl[k].n, tbl[k].po, tbl[k].f);
      chk($sformatf("t%0d_valid", k),  obs_v, tbl[k].ev);
      chk($sformatf("t%0d_instr", k),  obs_i, tbl[k].ei);
      chk($sformatf("t%0d_npc", k),    obs_n, tbl[k].en);
      chk($sformatf("t%0d_count", k),  obs_c, tbl[k].ec);
      chk($sformatf("t%0d_ready", k),  obs_r, tbl[k].er);
      chk($sformatf("t%0d_halted", k), obs_h, tbl[k].eh);
    end

    // full queue, simultaneous push and pop: pointer wrap
    for (int k = 0; k < 4; k++) cyc(1, 1, 32'h11 + k, 32'h200 + 4 * k, 0, 0);
    cyc(1, 1, 32'h9, 32'h300, 1, 0);
    idle();
    chk("wrap_count", obs_c, 4);
    chk("wrap_head",  obs_i, 32'h12);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 1, 0);
    chk("wrap_last", obs_i, 32'h9);
    idle();
    chk("wrap_empty", obs_v, 1'b0);

    // flush with wrong-path push in the same cycle
    for (int k = 0; k < 3; k++) cyc(1, 1, 32'h21 + k, 32'h400 + 4 * k, 0, 0);
    cyc(1, 1, 32'hAA, 32'h500, 0, 1);
    idle();
    chk("flush_count", obs_c, 0);
    chk("flush_instr", obs_i, 32'h0);
    idle();

    // halt: enqueued, blocks further pushes, drains in order, cleared by flush
    cyc(1, 1, 32'h31, 32'h600, 0, 0);
    cyc(1, 1, 32'hFC00_0000, 32'h604, 0, 0);
    cyc(1, 1, 32'h33, 32'h608, 0, 0);
    chk("halt_flag",  obs_h, 1'b1);
    chk("halt_ready", obs_r, 1'b0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("halt_d0", obs_i, 32'h31);
    cyc(1, 0, 0, 0, 1, 0);
    chk("halt_d1", obs_i, 32'hFC00_0000);
    cyc(1, 1, 32'h44, 32'h700, 0, 0);
    chk("halt_drop", obs_v, BYP ? 1'b0 : 1'b0);
    cyc(1, 0, 0, 0, 0, 1);
    idle();
    chk("halt_clr",  obs_h, 1'b0);
    chk("halt_rdy1", obs_r, 1'b1);

    // empty queue push+pop: bypass vs bubble
    cyc(1, 1, 32'h1234_5678, 32'h800, 1, 0);
    chk("byp_instr", obs_i, BYP ? 32'h1234_5678 : 32'h0);
    idle();
    chk("byp_count", obs_c, BYP ? 0 : 1);
    cyc(1, 0, 0, 0, 1, 0);
    idle();

    // randomized traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      bit rn, p, po, f;
      logic [31:0] i, n;
      rn = ($urandom % 100) != 0;
      p  = ($urandom % 3) != 0;
      po = ($urandom % 2) != 0;
      f  = ($urandom % 20) == 0;
      i  = $urandom;
      n  = $urandom;
      if (($urandom % 16) == 0) i[31:26] = 6'b111111;
      if (!rn) p = 0;
      cyc(rn, p, i, n, po, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
